// File: rtl/cap17_mem_pkg.sv
// Shared definitions for the CAP17 data-memory access sequencer.
package cap17_mem_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      B0   = 2'd1,
      B1   = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

endpackage

// File: rtl/mem_word_ctrl.sv
// Splits 8/16-bit load/store requests into byte accesses on an 8-bit memory
// and reassembles load data little-endian into a single completion pulse.
module mem_word_ctrl
   import cap17_mem_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_size,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   output logic              rsp_valid,
   output logic [15:0]       rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic [7:0]        mem_rdata
);

   state_e            r_state;
   state_e            w_state_next;
   logic              w_handshake;

   logic [ADDR_W-1:0] r_addr;
   logic              r_write;
   logic              r_size;
   logic [15:0]       r_wdata;
   logic [7:0]        r_rd_lo;
   logic              r_rsp_valid;
   logic [15:0]       r_rsp_rdata;

   assign req_ready   = (r_state == IDLE) & ~reset;
   assign w_handshake = req_valid & req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (w_handshake) w_state_next = B0;
         B0:      w_state_next = (r_size == SZ_WORD) ? B1 : DONE;
         B1:      w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Write enable is masked by reset so an interrupted word store never
   // commits its high byte in the reset cycle.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = 8'h00;
      mem_we    = 1'b0;
      unique case (r_state)
         B0: begin
            mem_addr  = r_addr;
            mem_wdata = r_wdata[7:0];
            mem_we    = r_write & ~reset;
         end
         B1: begin
            mem_addr  = r_addr + ADDR_W'(1);
            mem_wdata = r_wdata[15:8];
            mem_we    = r_write & ~reset;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_write     <= 1'b0;
         r_size      <= SZ_BYTE;
         r_wdata     <= 16'h0000;
         r_rd_lo     <= 8'h00;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= 16'h0000;
      end else begin
         r_state     <= w_state_next;
         r_rsp_valid <= (r_state == DONE);
         if (w_handshake) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_size  <= req_size;
            r_wdata <= req_wdata;
         end
         if (r_state == B1 && !r_write) begin
            r_rd_lo <= mem_rdata;
         end
         // Byte for the last-presented address arrives during DONE.
         if (r_state == DONE && !r_write) begin
            if (r_size == SZ_WORD) begin
               r_rsp_rdata <= {mem_rdata, r_rd_lo};
            end else begin
               r_rsp_rdata <= {8'h00, mem_rdata};
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Bench for mem_word_ctrl: transaction-level reference with an attached
// byte memory, checked every cycle, plus hand-computed literal expectations.
module tb_mem_word_ctrl;

   localparam int N = 1024;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic        req_size = 1'b0;
   logic [11:0] req_addr = 12'h000;
   logic [15:0] req_wdata = 16'h0000;
   logic        req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   always #5 clk = ~clk;

   mem_word_ctrl #(.ADDR_W(12)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_size  (req_size),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [7:0] init_byte(int a);
      logic [11:0] x;
      x = 12'(a);
      return x[7:0] ^ {x[11:8], 4'h3};
   endfunction

   // Attached data memory: synchronous read, one-cycle latency.
   logic [7:0] dmem [4096];
   logic [7:0] dmem_q;
   bit         dmem_init = 1'b0;
   assign mem_rdata = dmem_q;

   always @(posedge clk) begin
      if (!dmem_init) begin
         for (int i = 0; i < 4096; i++) dmem[i] = init_byte(i);
         dmem_init = 1'b1;
      end
      dmem_q <= dmem[mem_addr];
      if (mem_we) dmem[mem_addr] = mem_wdata;
   end

   // Reference state: expected bus/response per absolute cycle.
   bit          e_we  [N];
   logic [11:0] e_addr[N];
   logic [7:0]  e_wd  [N];
   bit          e_rv  [N];
   bit          e_ld  [N];
   logic [15:0] e_rd  [N];
   bit          e_clr [N];
   logic [7:0]  rmem  [4096];
   bit          rmem_init = 1'b0;
   logic [15:0] m_rd = 16'h0000;
   int          cyc = 0;
   int          free_at = 0;
   int          hs_cyc = -1;
   bit          started = 1'b0;

   // Literal expectations placed by the directed sequence.
   bit          l_bus [N];
   bit          l_we  [N];
   logic [11:0] l_addr[N];
   logic [7:0]  l_wd  [N];
   bit          l_rsp [N];
   logic [15:0] l_rd  [N];
   bit          l_nrsp[N];

   int total = 0;
   int bad = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic compare();
      int t;
      bit xwe;
      t = cyc;
      if (!rmem_init) begin
         for (int i = 0; i < 4096; i++) rmem[i] = init_byte(i);
         rmem_init = 1'b1;
      end
      if (!started || t >= N) return;
      if (e_clr[t]) m_rd = 16'h0000;
      if (e_rv[t] && e_ld[t]) m_rd = e_rd[t];
      xwe = e_we[t] && !reset;
      chk("req_ready", req_ready, (t >= free_at) && !reset);
      chk("mem_we", mem_we, xwe);
      chk("mem_addr", mem_addr, e_addr[t]);
      chk("mem_wdata", mem_wdata, e_wd[t]);
      chk("rsp_valid", rsp_valid, e_rv[t]);
      chk("rsp_rdata", rsp_rdata, m_rd);
      if (xwe) rmem[e_addr[t]] = e_wd[t];
      if (l_bus[t]) begin
         chk("lit_we", mem_we, l_we[t]);
         chk("lit_addr", mem_addr, l_addr[t]);
         chk("lit_wdata", mem_wdata, l_wd[t]);
      end
      if (l_rsp[t]) begin
         chk("lit_rsp_valid", rsp_valid, 1);
         chk("lit_rsp_rdata", rsp_rdata, l_rd[t]);
      end
      if (l_nrsp[t]) begin
         chk("lit_no_rsp", rsp_valid, 0);
         chk("lit_rdata_cleared", rsp_rdata, 0);
      end
   endtask

   task automatic model();
      int t;
      logic [11:0] a;
      logic [11:0] a1;
      t = cyc;
      if (t + 5 < N) begin
         if (reset) begin
            started = 1'b1;
            for (int k = 1; k <= 5; k++) begin
               e_we[t+k] = 1'b0; e_addr[t+k] = 12'h000; e_wd[t+k] = 8'h00;
               e_rv[t+k] = 1'b0; e_ld[t+k] = 1'b0;
            end
            e_clr[t+1] = 1'b1;
            free_at = t + 1;
         end else if (started && req_valid && t >= free_at) begin
            hs_cyc = t;
            a  = req_addr;
            a1 = req_addr + 12'd1;
            e_we[t+1] = req_write; e_addr[t+1] = a; e_wd[t+1] = req_wdata[7:0];
            if (req_size) begin
               e_we[t+2] = req_write; e_addr[t+2] = a1; e_wd[t+2] = req_wdata[15:8];
               e_rv[t+4] = 1'b1; e_ld[t+4] = !req_write; e_rd[t+4] = {rmem[a1], rmem[a]};
               free_at = t + 4;
            end else begin
               e_rv[t+3] = 1'b1; e_ld[t+3] = !req_write; e_rd[t+3] = {8'h00, rmem[a]};
               free_at = t + 3;
            end
         end
      end
      cyc = cyc + 1;
   endtask

   task automatic tick();
      @(negedge clk);
      compare();
      @(posedge clk);
      model();
      #1;
   endtask

   task automatic ticks(int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Leaves req_valid high; returns the handshake cycle.
   task automatic do_req(input bit w, input bit sz, input logic [11:0] a,
                         input logic [15:0] d, output int hs);
      req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = d;
      hs_cyc = -1;
      for (int i = 0; i < 20 && hs_cyc < 0; i++) tick();
      chk("handshake_seen", hs_cyc >= 0, 1);
      hs = hs_cyc;
   endtask

   task automatic set_bus(int c, bit we, logic [11:0] a, logic [7:0] d);
      l_bus[c] = 1'b1; l_we[c] = we; l_addr[c] = a; l_wd[c] = d;
   endtask

   task automatic set_rsp(int c, logic [15:0] d);
      l_rsp[c] = 1'b1; l_rd[c] = d;
   endtask

   initial begin
      int hs;
      int hs2;
      ticks(3);
      reset = 1'b0;
      ticks(2);

      // Word store 0xBEEF at 0x010; store leaves rsp_rdata at its reset value.
      do_req(1'b1, 1'b1, 12'h010, 16'hBEEF, hs);
      req_valid = 1'b0;
      set_bus(hs + 1, 1'b1, 12'h010, 8'hEF);
      set_bus(hs + 2, 1'b1, 12'h011, 8'hBE);
      set_rsp(hs + 4, 16'h0000);
      ticks(5);

      do_req(1'b0, 1'b1, 12'h010, 16'h0000, hs);
      req_valid = 1'b0;
      set_rsp(hs + 4, 16'hBEEF);
      ticks(5);

      do_req(1'b0, 1'b0, 12'h011, 16'h0000, hs);
      req_valid = 1'b0;
      set_rsp(hs + 3, 16'h00BE);
      ticks(4);

      // Wrap at the top of the address space.
      do_req(1'b1, 1'b1, 12'hFFF, 16'h1234, hs);
      req_valid = 1'b0;
      set_bus(hs + 1, 1'b1, 12'hFFF, 8'h34);
      set_bus(hs + 2, 1'b1, 12'h000, 8'h12);
      ticks(5);
      do_req(1'b0, 1'b1, 12'hFFF, 16'h0000, hs);
      req_valid = 1'b0;
      set_rsp(hs + 4, 16'h1234);
      ticks(5);

      // Back-to-back word loads, address wiggled while busy.
      do_req(1'b0, 1'b1, 12'h100, 16'h0000, hs);
      set_bus(hs + 1, 1'b0, 12'h100, 8'h00);
      set_bus(hs + 2, 1'b0, 12'h101, 8'h00);
      req_addr = 12'h3AB; tick();
      req_addr = 12'h3AC; tick();
      req_addr = 12'h3AD; tick();
      set_rsp(hs + 4, 16'h1213);
      do_req(1'b0, 1'b1, 12'h200, 16'h0000, hs2);
      chk("b2b_handshake_cycle", hs2, hs + 4);
      req_valid = 1'b0;
      set_rsp(hs2 + 4, 16'h2223);
      ticks(6);

      // Reset during the high-byte cycle of a word store.
      do_req(1'b1, 1'b1, 12'h020, 16'hAAAA, hs);
      req_valid = 1'b0;
      set_bus(hs + 1, 1'b1, 12'h020, 8'hAA);
      tick();
      reset = 1'b1;
      set_bus(hs + 2, 1'b0, 12'h021, 8'hAA);
      tick();
      reset = 1'b0;
      set_bus(hs + 3, 1'b0, 12'h000, 8'h00);
      l_nrsp[hs + 3] = 1'b1;
      l_nrsp[hs + 4] = 1'b1;
      ticks(4);

      do_req(1'b0, 1'b0, 12'h020, 16'h0000, hs);
      req_valid = 1'b0;
      set_rsp(hs + 3, 16'h00AA);
      ticks(4);
      do_req(1'b0, 1'b0, 12'h021, 16'h0000, hs);
      req_valid = 1'b0;
      set_rsp(hs + 3, 16'h0022);
      ticks(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_word_ctrl.md
# mem_word_ctrl

Word/byte access sequencer between the CAP17 datapath and the 8-bit, 4096-entry data memory. It accepts one 16-bit or 8-bit load/store request per handshake and splits it into byte accesses on the memory port. It reassembles read bytes little-endian and returns a single completion pulse. The block sits directly upstream of the data memory and drives all of its address, data and write-enable inputs.

## Interface
- ADDR_W, 12, memory byte-address width; the address space wraps at 2^ADDR_W.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  1  0 = byte, 1 = word (16-bit).
- req_addr  in  ADDR_W  byte address; the low byte is at this address.
- req_wdata  in  16  store data; only [7:0] is used for a byte store.
- rsp_valid  out  1  one-cycle completion pulse, for loads and stores.
- rsp_rdata  out  16  load result; valid when rsp_valid is high.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  8  memory write byte.
- mem_we  out  1  memory write enable.
- mem_rdata  in  8  memory read byte, valid in the cycle after its address is presented.

## Operation
- States: IDLE, B0, B1, DONE.
- Transitions:
  - IDLE→B0 on handshake (req_valid & req_ready).
  - B0→B1 if the latched size is word.
  - B0→DONE if the latched size is byte.
  - B1→DONE.
  - DONE→IDLE, unconditionally.
- req_ready = (state == IDLE) & ~reset.
- Request inputs are ignored outside IDLE.
- addr, write, size and wdata are latched at the handshake edge; later input changes have no effect.
- B0: mem_addr = A, mem_wdata = wdata[7:0], mem_we = write.
- B1: mem_addr = (A+1) mod 2^ADDR_W, mem_wdata = wdata[15:8], mem_we = write.
- DONE and IDLE: mem_addr = 0, mem_wdata = 0, mem_we = 0.
- Word load:
  - mem_rdata is captured into the low byte at the end of B1.
  - mem_rdata is captured into the high byte at the end of DONE.
- Byte load: mem_rdata is captured into [7:0] at the end of DONE; [15:8] = 0x00.
- Leaving DONE, the block registers rsp_valid = 1 for one cycle.
  - On a load, rsp_rdata is updated from the assembled bytes.
  - On a store, rsp_rdata holds its previous value.
- Address wrap: A = 0xFFF for a word access uses 0xFFF, then 0x000.
- Misaligned word addresses are legal; there is no alignment check.

## Timing
- Reset (synchronous) sets:
  - state = IDLE
  - rsp_valid = 0
  - rsp_rdata = 0x0000
  - mem_we = 0, mem_addr = 0, mem_wdata = 0
  - req_ready = 0 while reset is high
- Cycle numbering, with the handshake in cycle 0:
  - Word access: B0 in cycle 1, B1 in cycle 2, DONE in cycle 3, rsp_valid in cycle 4.
  - Byte access: B0 in cycle 1, DONE in cycle 2, rsp_valid in cycle 3.
- req_ready is high again in the rsp_valid cycle, so a new handshake may coincide with rsp_valid.
  - Word throughput: one access per 4 cycles.
  - Byte throughput: one access per 3 cycles.
- mem_addr, mem_wdata and mem_we are decoded from the state register and latched request. They are glitch-free per cycle and stable for the full cycle.
- Reset mid-operation:
  - The FSM returns to IDLE and mem_we is 0 from the next cycle.
  - No rsp_valid is issued.
  - A word store interrupted after B0 leaves only the low byte written. This is accepted behaviour.
- reset and req_valid both high in the same cycle: no handshake.

## Structure
- Shared package cap17_mem_pkg holds:
  - ADDR_W default
  - the state enum (IDLE, B0, B1, DONE)
  - size encodings SZ_BYTE = 0 and SZ_WORD = 1
- No sub-module. The block is a single FSM with a request-latch register set and a 16-bit read-assembly register.

## Test plan
- After reset: req_ready = 1, rsp_valid = 0, rsp_rdata = 0x0000, mem_we = 0.
- Word store, A = 0x010, data = 0xBEEF:
  - cycle 1: mem_we = 1, mem_addr = 0x010, mem_wdata = 0xEF
  - cycle 2: mem_we = 1, mem_addr = 0x011, mem_wdata = 0xBE
  - cycle 4: rsp_valid = 1
- Word load from 0x010 after that store: rsp_valid in cycle 4 with rsp_rdata = 0xBEEF. Then a byte load from 0x011: rsp_rdata = 0x00BE in cycle 3.
- Word store 0x1234 at A = 0xFFF:
  - writes 0x34 to 0xFFF and 0x12 to 0x000
  - a word load from 0xFFF then returns 0x1234
- Back-to-back word loads with req_valid held high:
  - second handshake in the first rsp_valid cycle
  - responses 4 cycles apart
  - req_addr changed in cycles 1–3 does not alter the in-flight access
- Reset asserted in cycle 2 of a word store to 0x020 with data 0xAAAA:
  - mem_we = 0 from cycle 3
  - no rsp_valid
  - 0x020 holds 0xAA and 0x021 is unchanged
